// File: rtl/alu_exec_ctrl_if.sv
// Instruction channel into the execute-stage controller: valid/ready handshake plus
// the register-addressed instruction fields.
interface alu_exec_ctrl_if #(
    parameter int unsigned REG_ADDR_W = 2
);
    logic                  valid;
    logic                  ready;
    logic [1:0]            op;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs;
    logic [2:0]            cnt;

    modport master (output valid, op, rd, rs, cnt, input ready);
    modport slave  (input valid, op, rd, rs, cnt, output ready);
endinterface

// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller wrapped around an external 8-bit combinational ALU.
// Reads operands from a small register file, iterates 1-bit shifts, writes back result and flags.
module alu_exec_ctrl #(
    parameter int unsigned REG_ADDR_W = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_exec_ctrl_if.slave        instr,
    input  logic                  ld_en,
    input  logic [REG_ADDR_W-1:0] ld_addr,
    input  logic [7:0]            ld_data,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    output logic [7:0]            rd_data,
    output logic [7:0]            alu_a,
    output logic [7:0]            alu_b,
    output logic [1:0]            alu_op,
    input  logic [7:0]            alu_result,
    input  logic                  alu_carry,
    input  logic                  alu_overflow,
    input  logic                  alu_negative,
    input  logic                  alu_zero,
    output logic [3:0]            flags,
    output logic                  done
);
    localparam int unsigned Depth = 2 ** REG_ADDR_W;

    typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

    state_e                state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [REG_ADDR_W-1:0] rs_q, rs_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  first_q, first_d;
    logic [7:0]            acc_q, acc_d;
    logic [3:0]            cflags_q, cflags_d;
    logic [3:0]            flags_q, flags_d;
    logic [7:0]            regs_q [Depth];

    logic       accept;
    logic       ld_hit;
    logic       wb_en;
    logic [7:0] rd_cur;

    assign ld_hit      = ld_en && (state_q == StIdle);
    assign accept      = instr.valid && (state_q == StIdle);
    assign wb_en       = (state_q == StWb);
    assign instr.ready = (state_q == StIdle);
    assign done        = wb_en;
    assign flags       = flags_q;
    assign rd_data     = regs_q[rd_addr];

    // A load in the accept cycle must be visible to a zero-count shift, which never reads the ALU.
    assign rd_cur = (ld_hit && (ld_addr == instr.rd)) ? ld_data : regs_q[instr.rd];

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        rs_d     = rs_q;
        cnt_d    = cnt_q;
        first_d  = first_q;
        acc_d    = acc_q;
        cflags_d = cflags_q;
        flags_d  = flags_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d  = instr.op;
                    rd_d  = instr.rd;
                    rs_d  = instr.rs;
                    cnt_d = instr.cnt;
                    if (!instr.op[1] && (instr.cnt == 3'd0)) begin
                        state_d  = StWb;
                        acc_d    = rd_cur;
                        cflags_d = {rd_cur[7], rd_cur == 8'h00, 2'b00};
                    end else begin
                        state_d = StExec;
                        first_d = 1'b1;
                    end
                end
            end
            StExec: begin
                acc_d    = alu_result;
                cflags_d = {alu_negative, alu_zero, alu_carry, alu_overflow};
                first_d  = 1'b0;
                cnt_d    = cnt_q - 3'd1;
                if (op_q[1] || (cnt_q == 3'd1)) begin
                    state_d = StWb;
                end
            end
            StWb: begin
                flags_d = cflags_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        alu_a  = 8'h00;
        alu_b  = 8'h00;
        alu_op = 2'b00;
        if (state_q == StExec) begin
            alu_op = op_q;
            alu_b  = regs_q[rs_q];
            alu_a  = first_q ? regs_q[rd_q] : acc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            op_q     <= 2'b00;
            rd_q     <= '0;
            rs_q     <= '0;
            cnt_q    <= 3'd0;
            first_q  <= 1'b0;
            acc_q    <= 8'h00;
            cflags_q <= 4'h0;
            flags_q  <= 4'h0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            rs_q     <= rs_d;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
            acc_q    <= acc_d;
            cflags_q <= cflags_d;
            flags_q  <= flags_d;
        end
    end

    // Loads and write-back are mutually exclusive by state, so no priority conflict.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < Depth; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else if (wb_en) begin
            regs_q[rd_q] <= acc_q;
        end else if (ld_hit) begin
            regs_q[ld_addr] <= ld_data;
        end
    end
endmodule

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
- Execute-stage controller that sits directly upstream and downstream of the 8-bit combinational ALU (ops SHL, SHR, ADD, SUB; flags N, Z, C, V).
- Accepts register-addressed instructions over a valid/ready handshake and reads operands from an internal 4x8 register file.
- Drives the ALU operand/op inputs and captures its result and flags.
- Multi-bit shifts are done by iterating the ALU's 1-bit shift; the result is written back and a flag register is updated.

Parameters:
REG_ADDR_W, 2, register address width; register file depth = 2**REG_ADDR_W, each entry 8 bits.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
instr_valid  input  1  instruction offered
instr_ready  output  1  controller can accept; equals (state==IDLE)
instr_op  input  2  00 SHL, 01 SHR, 10 ADD, 11 SUB
instr_rd  input  REG_ADDR_W  destination and A-operand register
instr_rs  input  REG_ADDR_W  B-operand register (ignored for shifts)
instr_cnt  input  3  shift count 0..7 (ignored for ADD/SUB)
ld_en  input  1  register-file load strobe
ld_addr  input  REG_ADDR_W  load address
ld_data  input  8  load data
rd_addr  input  REG_ADDR_W  debug read address
rd_data  output  8  combinational R[rd_addr]
alu_a  output  8  to ALU a
alu_b  output  8  to ALU b
alu_op  output  2  to ALU op
alu_result  input  8  from ALU result
alu_carry, alu_overflow, alu_negative, alu_zero  input  1 each  from ALU flags
flags  output  4  registered {N,Z,C,V}
done  output  1  one-cycle pulse in write-back cycle

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: state=IDLE, all registers 0x00, flags=0, done=0, latched fields 0. Reset mid-instruction aborts it: no write-back, no done.
- States:
  - IDLE: instr_ready=1. On instr_valid, latch op/rd/rs/cnt, then go to EXEC. Exception: a shift with cnt=0 goes straight to WB.
  - EXEC: ADD/SUB take exactly 1 cycle. Shifts take cnt cycles; the step counter decrements each cycle. Go to WB after the last step.
  - WB: write acc to R[rd], load flags from the captured flags, pulse done=1, return to IDLE.
- Latency: done is high in cycle T+1+k, where T is the accept cycle; k=1 for ADD/SUB, k=cnt for shifts (cnt=0 gives done at T+1). Next accept possible at T+2+k.
- ALU drive in EXEC:
  - alu_op = latched op; alu_b = R[rs].
  - alu_a = R[rd] on the first EXEC cycle, acc on later cycles.
- ALU drive in IDLE/WB: alu_a, alu_b and alu_op are all 0.
- Capture: every EXEC cycle, acc <= alu_result and the captured flags <= the ALU flags. Multi-step shifts therefore report C from the final step only; V=0.
- cnt=0 shift: WB writes R[rd] unchanged. Flags: C=0, V=0; N=R[rd][7]; Z=(R[rd]==0).
- Flags are unchanged except in WB.
- Load port:
  - Honoured only in IDLE; ignored otherwise.
  - If a load and an instruction accept happen in the same cycle, the load writes first and the instruction sees the new value.
  - rd==rs is legal: ADD then computes R+R.
- instr_valid while not IDLE: ignored, no side effects. Instruction fields need only be stable in the accept cycle.
- rd_data is combinational from the register file. It shows the WB write from the following cycle.

Test Plan:
- Reset: load registers, assert rst for 1 cycle -> all R=0x00, flags=0, done=0, instr_ready=1 in the next cycle.
- ADD: R0=0x7F, R1=0x01, ADD rd=0 rs=1 accepted at T -> done at T+2, R0=0x80, flags N=1 Z=0 C=0 V=1.
- SUB borrow: R2=0x00, R3=0x01, SUB rd=2 rs=3 -> R2=0xFF, N=1 Z=0 C=1 V=0, done at T+2.
- SHL multi-step: R1=0xB1, SHL rd=1 cnt=3 -> alu_a sequence 0xB1, 0x62, 0xC4; done at T+4; R1=0x88, N=1 Z=0 C=1 V=0. instr_valid held high during busy -> ignored, instr_ready=0.
- Zero count / load collision: ld_en (addr 2, data 0x00) in the same cycle as accepting SHR rd=2 cnt=0 -> done at T+1, R2=0x00, flags N=0 Z=1 C=0 V=0.
- Reset mid-shift: SHR cnt=7 on 0x80, rst at T+3 -> no done; R unchanged from reset (0x00); state IDLE; accepts a new instruction the cycle after rst deasserts.
